// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the sequenced ALU controller.
package alu_ctrl_pkg;

    // Major opcode classes presented by the instruction decoder.
    typedef enum logic [1:0] {
        AOP_NOP   = 2'd0,
        AOP_ARITH = 2'd1,
        AOP_SHIFT = 2'd2,
        AOP_CMP   = 2'd3
    } aluop_e;

    // Function field codes for arithmetic/logic instructions.
    typedef enum logic [2:0] {
        FN_ADD  = 3'd0,
        FN_ADDC = 3'd1,
        FN_SUB  = 3'd2,
        FN_SUBC = 3'd3,
        FN_AND  = 3'd4,
        FN_OR   = 3'd5,
        FN_XOR  = 3'd6,
        FN_MASK = 3'd7
    } fn_arith_e;

    // Function field codes for shift/rotate instructions (only fn[1:0] selects).
    typedef enum logic [2:0] {
        FN_SHL = 3'd0,
        FN_SHR = 3'd1,
        FN_ROL = 3'd2,
        FN_ROR = 3'd3
    } fn_shift_e;

    localparam logic [3:0] CMP_OP = 4'b1100;
    localparam logic [3:0] NOP_OP = 4'b0000;

    // Controller sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_SHIFT = 2'd2
    } state_e;

    // ALU op code for a single shift/rotate step.
    function automatic logic [3:0] shift_op(input logic [1:0] sel);
        return {2'b10, sel};
    endfunction

endpackage

// File: rtl/alu_ctrl_seq_step_cnt.sv
// Shift step down-counter: load, decrement, clear; flags for the last two steps.
module alu_step_cnt #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    input  logic         clr,
    output logic         last,
    output logic         penult
);

    logic [W-1:0] cnt_r;

    // Step counter register; clear wins over load, load wins over decrement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {W{1'b0}};
        end else if (clr) begin
            cnt_r <= {W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (dec) begin
            cnt_r <= cnt_r - W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // last marks the final step; penult lets the controller register done one step ahead.
    assign last   = (cnt_r == W'(1));
    assign penult = (cnt_r == W'(2));

endmodule

// File: rtl/alu_ctrl_seq.sv
// Sequenced ALU controller: decodes one instruction per handshake and
// expands multi-bit shifts/rotates into single-bit ALU steps.
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int SHAMT_W    = 3,
    parameter bit ILLEGAL_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         aluop,
    input  logic [2:0]         fn,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               abort,
    output logic [3:0]         alu_op,
    output logic               ld,
    output logic               busy,
    output logic               done,
    output logic               illegal
);

    state_e     state_r, state_nxt_s;
    logic [3:0] alu_op_r, alu_op_nxt_s;
    logic       ld_r, ld_nxt_s;
    logic       busy_r;
    logic       done_r, done_nxt_s;
    logic       illegal_r, illegal_nxt_s;
    logic       in_ready_s;
    logic       cnt_load_s, cnt_dec_s, cnt_clr_s;
    logic       cnt_last_s, cnt_penult_s;

    assign in_ready_s = (state_r == ST_IDLE) && !abort;

    alu_step_cnt #(
        .W (SHAMT_W)
    ) u_step_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load_s),
        .load_val (shamt),
        .dec      (cnt_dec_s),
        .clr      (cnt_clr_s),
        .last     (cnt_last_s),
        .penult   (cnt_penult_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state, decode and next-output logic; everything defaults to an idle, cleared cycle.
    always_comb begin
        state_nxt_s   = state_r;
        alu_op_nxt_s  = NOP_OP;
        ld_nxt_s      = 1'b0;
        done_nxt_s    = 1'b0;
        illegal_nxt_s = 1'b0;
        cnt_load_s    = 1'b0;
        cnt_dec_s     = 1'b0;
        cnt_clr_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (in_valid && in_ready_s) begin
                    case (aluop_e'(aluop))
                        AOP_NOP: begin
                            state_nxt_s = ST_EXEC;
                            done_nxt_s  = 1'b1;
                        end
                        AOP_ARITH: begin
                            state_nxt_s  = ST_EXEC;
                            alu_op_nxt_s = {1'b0, fn};
                            ld_nxt_s     = 1'b1;
                            done_nxt_s   = 1'b1;
                        end
                        AOP_CMP: begin
                            state_nxt_s  = ST_EXEC;
                            alu_op_nxt_s = CMP_OP;
                            done_nxt_s   = 1'b1;
                        end
                        AOP_SHIFT: begin
                            if (ILLEGAL_EN && fn[2]) begin
                                state_nxt_s   = ST_EXEC;
                                illegal_nxt_s = 1'b1;
                                done_nxt_s    = 1'b1;
                            end else if (shamt == {SHAMT_W{1'b0}}) begin
                                state_nxt_s  = ST_EXEC;
                                alu_op_nxt_s = shift_op(fn[1:0]);
                                done_nxt_s   = 1'b1;
                            end else begin
                                state_nxt_s  = ST_SHIFT;
                                alu_op_nxt_s = shift_op(fn[1:0]);
                                ld_nxt_s     = 1'b1;
                                done_nxt_s   = (shamt == SHAMT_W'(1));
                                cnt_load_s   = 1'b1;
                            end
                        end
                        default: begin
                            state_nxt_s = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                state_nxt_s = ST_IDLE;
                cnt_clr_s   = 1'b1;
            end
            ST_SHIFT: begin
                if (abort || cnt_last_s) begin
                    state_nxt_s = ST_IDLE;
                    cnt_clr_s   = 1'b1;
                end else begin
                    // Hold the op and keep loading; done is raised one step early so it lands on cnt==1.
                    state_nxt_s  = ST_SHIFT;
                    alu_op_nxt_s = alu_op_r;
                    ld_nxt_s     = 1'b1;
                    done_nxt_s   = cnt_penult_s;
                    cnt_dec_s    = 1'b1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_clr_s   = 1'b1;
            end
        endcase
    end

    // Registered outputs; busy mirrors the state that the next cycle will be in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_op_r  <= NOP_OP;
            ld_r      <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            illegal_r <= 1'b0;
        end else begin
            alu_op_r  <= alu_op_nxt_s;
            ld_r      <= ld_nxt_s;
            busy_r    <= (state_nxt_s != ST_IDLE);
            done_r    <= done_nxt_s;
            illegal_r <= illegal_nxt_s;
        end
    end

    assign in_ready = in_ready_s;
    assign alu_op   = alu_op_r;
    assign ld       = ld_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign illegal  = illegal_r;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq: directed steps then random instructions,
// compared against a per-instruction behavioural model for both decode modes.
module tb_alu_ctrl_seq;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [1:0] aluop;
    logic [2:0] fn;
    logic [2:0] shamt;
    logic       abort;

    logic       rdy_a, ld_a, busy_a, done_a, ill_a;
    logic [3:0] op_a;
    logic       rdy_b, ld_b, busy_b, done_b, ill_b;
    logic [3:0] op_b;

    int n_vec = 0;
    int n_err = 0;

    // Design with illegal-shift detection enabled.
    alu_ctrl_seq #(.SHAMT_W(3), .ILLEGAL_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a),
        .aluop(aluop), .fn(fn), .shamt(shamt), .abort(abort),
        .alu_op(op_a), .ld(ld_a), .busy(busy_a), .done(done_a), .illegal(ill_a)
    );

    // Legacy-decode copy: fn[2] ignored for shifts.
    alu_ctrl_seq #(.SHAMT_W(3), .ILLEGAL_EN(1'b0)) dut_legacy (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_b),
        .aluop(aluop), .fn(fn), .shamt(shamt), .abort(abort),
        .alu_op(op_b), .ld(ld_b), .busy(busy_b), .done(done_b), .illegal(ill_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observation vector: {in_ready, busy, illegal, done, ld, alu_op}.
    logic [8:0] obs_a, obs_b;
    assign obs_a = {rdy_a, busy_a, ill_a, done_a, ld_a, op_a};
    assign obs_b = {rdy_b, busy_b, ill_b, done_b, ld_b, op_b};

    localparam logic [8:0] IDLE_V = 9'h100;

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Instruction-level model: length in cycles and the constant op/ld/illegal it produces.
    function automatic void model(input bit en, input int aop, input int f, input int sh,
                                  output int len, output logic [3:0] op,
                                  output logic ldv, output logic ill);
        len = 1; op = 4'd0; ldv = 1'b0; ill = 1'b0;
        if (aop == 1) begin
            op = 4'(f); ldv = 1'b1;
        end else if (aop == 3) begin
            op = 4'd12;
        end else if (aop == 2) begin
            if (en && f >= 4) begin
                ill = 1'b1;
            end else begin
                op = 4'(8 + f % 4);
                if (sh > 0) begin
                    len = sh; ldv = 1'b1;
                end
            end
        end
    endfunction

    // Expected observation in cycle k after accept, abort asserted during cycle a.
    function automatic logic [8:0] expv(input int k, input int len, input int a,
                                        input logic [3:0] op, input logic ldv, input logic ill);
        if (k <= len && k <= a)
            return {1'b0, 1'b1, ill && (k == len), (k == len), ldv, op};
        else
            return {(k != a), 8'h00};
    endfunction

    // Issue one instruction, follow it to completion (or abort) and check every cycle.
    task automatic run(input string tag, input int aop, input int f, input int sh, input int a);
        int la, lb, kmax;
        logic [3:0] opa, opb;
        logic lda, ldb, ila, ilb;
        model(1'b1, aop, f, sh, la, opa, lda, ila);
        model(1'b0, aop, f, sh, lb, opb, ldb, ilb);
        aluop = 2'(aop); fn = 3'(f); shamt = 3'(sh); abort = 1'b0; in_valid = 1'b1;
        #1;
        check({tag, " ready_a"}, obs_a, IDLE_V);
        check({tag, " ready_b"}, obs_b, IDLE_V);
        @(posedge clk); #1;
        in_valid = 1'b0;
        aluop = 2'($urandom); fn = 3'($urandom); shamt = 3'($urandom);
        kmax = (la < a ? la : a);
        if ((lb < a ? lb : a) > kmax) kmax = (lb < a ? lb : a);
        for (int k = 1; k <= kmax; k++) begin
            abort = (k == a);
            #1;
            check($sformatf("%s a c%0d", tag, k), obs_a, expv(k, la, a, opa, lda, ila));
            check($sformatf("%s b c%0d", tag, k), obs_b, expv(k, lb, a, opb, ldb, ilb));
            @(posedge clk); #1;
        end
        abort = 1'b0;
        #1;
        check({tag, " end_a"}, obs_a, IDLE_V);
        check({tag, " end_b"}, obs_b, IDLE_V);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; aluop = 2'd0; fn = 3'd0; shamt = 3'd0; abort = 1'b0;
        #1;
        check("reset_a", obs_a, IDLE_V);
        check("reset_b", obs_b, IDLE_V);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("post_reset_a", obs_a, IDLE_V);

        run("sub", 1, 2, 0, 99);
        run("rol5", 2, 2, 5, 99);
        run("shr0", 2, 1, 0, 99);
        run("cmp", 3, 6, 4, 99);
        run("nop", 0, 7, 7, 99);
        run("ill_sh3", 2, 5, 3, 99);
        run("ill_sh0", 2, 6, 0, 99);
        run("shl1", 2, 0, 1, 99);
        run("ror7", 2, 3, 7, 99);
        run("mask", 1, 7, 2, 99);

        // Abort after the third step, then abort held in IDLE blocks a new instruction.
        run("abort3", 2, 1, 7, 3);
        abort = 1'b1; in_valid = 1'b1; aluop = 2'd1; fn = 3'd4;
        #1;
        check("abort_idle_a", obs_a, 9'h000);
        check("abort_idle_b", obs_b, 9'h000);
        @(posedge clk); #1;
        abort = 1'b0; in_valid = 1'b0;
        #1;
        check("abort_noacc_a", obs_a, IDLE_V);
        check("abort_noacc_b", obs_b, IDLE_V);

        // Asynchronous reset between edges during a shift.
        aluop = 2'd2; fn = 3'd3; shamt = 3'd6; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("midshift_a", obs_a, {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1011});
        #1 rst = 1'b1;
        #1;
        check("async_rst_a", obs_a, IDLE_V);
        check("async_rst_b", obs_b, IDLE_V);
        @(posedge clk); #1;
        check("rst_hold_a", obs_a, IDLE_V);
        rst = 1'b0;
        #1;
        run("after_rst", 1, 5, 0, 99);

        // Random instructions with occasional aborts and idle gaps.
        for (int i = 0; i < 60; i++) begin
            int aop, f, sh, a;
            aop = int'($urandom_range(0, 3));
            f   = int'($urandom_range(0, 7));
            sh  = int'($urandom_range(0, 7));
            a   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 99;
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
            run($sformatf("rnd%0d", i), aop, f, sh, a);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
